wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_pkg.sv | 41 ++++
 rtl/wb_arbiter_if.sv | 54 +++++
 rtl/wb_result_fifo.sv | 74 +++++++
 rtl/wb_arbiter.sv | 141 ++++++++++++++
 tb/tb_wb_arbiter.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter_pkg
// Description : Shared widths, source-select encoding and writeback entry type
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef SCOREBOARD_SIZE_WIDTH
`define SCOREBOARD_SIZE_WIDTH 4
`endif

package wb_arbiter_pkg;

    localparam int unsigned SB_W = `SCOREBOARD_SIZE_WIDTH;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_LSU = 2'd1,
        SRC_MDU = 2'd2
    } src_e;

    typedef struct packed {
        logic [SB_W-1:0] sid;
        logic [4:0]      rd;
        logic [63:0]     value;
    } wb_entry_t;

    localparam int unsigned ENTRY_W = $bits(wb_entry_t);

    // Round-robin successor: ALU -> LSU -> MDU -> ALU
    function automatic src_e rr_next(input src_e s);
        case (s)
            SRC_ALU: rr_next = SRC_LSU;
            SRC_LSU: rr_next = SRC_MDU;
            default: rr_next = SRC_ALU;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter_if
// Description : Result-source and writeback bus bundle for wb_arbiter
// Revision    : 1.0 - initial release
// ============================================================================

interface wb_arbiter_if;
    import wb_arbiter_pkg::*;

    logic            alu_exe_valid_i;
    logic [SB_W-1:0] alu_sid_i;
    logic [4:0]      alu_exe_rd_i;
    logic [63:0]     alu_exe_rd_value_i;

    logic            mdu_valid_i;
    logic            mdu_ready_o;
    logic [SB_W-1:0] mdu_sid_i;
    logic [4:0]      mdu_rd_i;
    logic [63:0]     mdu_value_i;

    logic            lsu_valid_i;
    logic            lsu_ready_o;
    logic [SB_W-1:0] lsu_sid_i;
    logic [4:0]      lsu_rd_i;
    logic [63:0]     lsu_value_i;

    logic            wb_valid_o;
    logic            wb_we_o;
    logic [4:0]      wb_rd_o;
    logic [63:0]     wb_value_o;
    logic [SB_W-1:0] wb_sid_o;

    modport slave (
        input  alu_exe_valid_i, alu_sid_i, alu_exe_rd_i, alu_exe_rd_value_i,
        input  mdu_valid_i, mdu_sid_i, mdu_rd_i, mdu_value_i,
        output mdu_ready_o,
        input  lsu_valid_i, lsu_sid_i, lsu_rd_i, lsu_value_i,
        output lsu_ready_o,
        output wb_valid_o, wb_we_o, wb_rd_o, wb_value_o, wb_sid_o
    );

    modport master (
        output alu_exe_valid_i, alu_sid_i, alu_exe_rd_i, alu_exe_rd_value_i,
        output mdu_valid_i, mdu_sid_i, mdu_rd_i, mdu_value_i,
        input  mdu_ready_o,
        output lsu_valid_i, lsu_sid_i, lsu_rd_i, lsu_value_i,
        input  lsu_ready_o,
        input  wb_valid_o, wb_we_o, wb_rd_o, wb_value_o, wb_sid_o
    );

endinterface

`default_nettype wire

// File: rtl/wb_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_result_fifo
// Description : Power-of-two synchronous FIFO with occupancy count
// Revision    : 1.0 - initial release
// ============================================================================

module wb_result_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic                   i_push,
    input  wire logic [WIDTH-1:0]       i_data,
    input  wire logic                   i_pop,
    output logic      [WIDTH-1:0]       o_data,
    output logic      [$clog2(DEPTH):0] o_count,
    output logic                        o_full,
    output logic                        o_empty
);

    localparam int unsigned c_ptr_w = $clog2(DEPTH);
    localparam int unsigned c_cnt_w = c_ptr_w + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_full;
    logic               w_empty;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_full    = (r_count == c_cnt_w'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~w_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign w_do_push = i_push & (~w_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Round-robin writeback arbiter for ALU (buffered), LSU and MDU
// Revision    : 1.0 - initial release
// ============================================================================

module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned ALU_FIFO_DEPTH = 4
) (
    input  wire logic                            clk,
    input  wire logic                            rst_n,
    wb_arbiter_if.slave                          bus,
    output logic [$clog2(ALU_FIFO_DEPTH):0]      alu_fifo_cnt_o,
    output logic                                 overflow_o
);

    localparam int unsigned c_cnt_w = $clog2(ALU_FIFO_DEPTH) + 1;
    localparam logic [c_cnt_w-1:0] c_force_lvl = c_cnt_w'(ALU_FIFO_DEPTH - 1);

    wb_entry_t          w_alu_in;
    wb_entry_t          w_alu_head;
    wb_entry_t          w_gnt_entry;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [c_cnt_w-1:0] w_cnt;
    logic [3:0]         w_req;
    logic               w_force;
    logic               w_gnt_valid;
    logic               w_alu_pop;
    src_e               w_gnt_src;
    src_e               w_first;
    src_e               w_second;
    src_e               w_third;

    src_e               r_last;
    logic               r_wb_valid;
    logic               r_wb_we;
    wb_entry_t          r_wb_entry;
    logic               r_overflow;

    assign w_alu_in.sid   = bus.alu_sid_i;
    assign w_alu_in.rd    = bus.alu_exe_rd_i;
    assign w_alu_in.value = bus.alu_exe_rd_value_i;

    wb_result_fifo #(
        .DEPTH (ALU_FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_alu_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (bus.alu_exe_valid_i),
        .i_data  (w_alu_in),
        .i_pop   (w_alu_pop),
        .o_data  (w_alu_head),
        .o_count (w_cnt),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_req   = {1'b0, bus.mdu_valid_i, bus.lsu_valid_i, ~w_fifo_empty};
    assign w_force = (w_cnt >= c_force_lvl);

    // Grants are suppressed while in reset so held upstream requests see no ready
    always_comb begin
        w_first     = rr_next(r_last);
        w_second    = rr_next(w_first);
        w_third     = rr_next(w_second);
        w_gnt_valid = 1'b0;
        w_gnt_src   = SRC_ALU;
        if (rst_n) begin
            if (w_force) begin
                w_gnt_valid = 1'b1;
                w_gnt_src   = SRC_ALU;
            end else if (w_req[w_first]) begin
                w_gnt_valid = 1'b1;
                w_gnt_src   = w_first;
            end else if (w_req[w_second]) begin
                w_gnt_valid = 1'b1;
                w_gnt_src   = w_second;
            end else if (w_req[w_third]) begin
                w_gnt_valid = 1'b1;
                w_gnt_src   = w_third;
            end
        end
    end

    always_comb begin
        w_gnt_entry = w_alu_head;
        case (w_gnt_src)
            SRC_LSU: begin
                w_gnt_entry.sid   = bus.lsu_sid_i;
                w_gnt_entry.rd    = bus.lsu_rd_i;
                w_gnt_entry.value = bus.lsu_value_i;
            end
            SRC_MDU: begin
                w_gnt_entry.sid   = bus.mdu_sid_i;
                w_gnt_entry.rd    = bus.mdu_rd_i;
                w_gnt_entry.value = bus.mdu_value_i;
            end
            default: w_gnt_entry = w_alu_head;
        endcase
    end

    assign w_alu_pop       = w_gnt_valid & (w_gnt_src == SRC_ALU);
    assign bus.lsu_ready_o = w_gnt_valid & (w_gnt_src == SRC_LSU);
    assign bus.mdu_ready_o = w_gnt_valid & (w_gnt_src == SRC_MDU);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid <= 1'b0;
            r_wb_we    <= 1'b0;
            r_wb_entry <= '0;
            r_last     <= SRC_MDU;
            r_overflow <= 1'b0;
        end else begin
            r_wb_valid <= w_gnt_valid;
            r_wb_we    <= w_gnt_valid & (w_gnt_entry.rd != 5'd0);
            if (w_gnt_valid) begin
                r_wb_entry <= w_gnt_entry;
                r_last     <= w_gnt_src;
            end
            if (bus.alu_exe_valid_i & w_fifo_full & ~w_alu_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.wb_valid_o = r_wb_valid;
    assign bus.wb_we_o    = r_wb_we;
    assign bus.wb_rd_o    = r_wb_entry.rd;
    assign bus.wb_value_o = r_wb_entry.value;
    assign bus.wb_sid_o   = r_wb_entry.sid;
    assign alu_fifo_cnt_o = w_cnt;
    assign overflow_o     = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter
// Description : Directed scoreboard bench for wb_arbiter
// Revision    : 1.0 - initial release
// ============================================================================

module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic                   clk   = 1'b0;
    logic                   rst_n = 1'b0;
    logic [$clog2(DEPTH):0] cnt;
    logic                   ovf;

    wb_arbiter_if bus();

    wb_arbiter #(.ALU_FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .alu_fifo_cnt_o (cnt),
        .overflow_o     (ovf)
    );

    always #5 clk = ~clk;

    wb_entry_t q_alu[$];
    wb_entry_t q_lsu[$];
    wb_entry_t q_mdu[$];
    wb_entry_t cur_alu, cur_lsu, cur_mdu, last_wb;
    int n_vec = 0;
    int n_err = 0;
    int lsu_left = 0, mdu_left = 0, alu_stream = 0;
    int lsu_seq = 0, mdu_seq = 0, alu_seq = 0;
    int max_cnt = 0;
    logic lsu_acc = 1'b0, mdu_acc = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic wb_entry_t mk(input logic [3:0] tag, input int seq);
        wb_entry_t e;
        e.sid   = SB_W'(seq);
        e.rd    = 5'(seq * 3);
        e.value = {tag, 44'd0, 16'(seq)};
        return e;
    endfunction

    task automatic drive_alu(input wb_entry_t e);
        cur_alu                = e;
        bus.alu_exe_valid_i    = 1'b1;
        bus.alu_sid_i          = e.sid;
        bus.alu_exe_rd_i       = e.rd;
        bus.alu_exe_rd_value_i = e.value;
    endtask

    task automatic apply();
        if (lsu_left > 0) begin
            cur_lsu         = mk(4'h2, lsu_seq);
            bus.lsu_valid_i = 1'b1;
            bus.lsu_sid_i   = cur_lsu.sid;
            bus.lsu_rd_i    = cur_lsu.rd;
            bus.lsu_value_i = cur_lsu.value;
        end else begin
            bus.lsu_valid_i = 1'b0;
        end
        if (mdu_left > 0) begin
            cur_mdu         = mk(4'h3, mdu_seq);
            bus.mdu_valid_i = 1'b1;
            bus.mdu_sid_i   = cur_mdu.sid;
            bus.mdu_rd_i    = cur_mdu.rd;
            bus.mdu_value_i = cur_mdu.value;
        end else begin
            bus.mdu_valid_i = 1'b0;
        end
        if (alu_stream > 0) begin
            drive_alu(mk(4'h1, alu_seq));
            alu_seq++;
            alu_stream--;
        end else begin
            bus.alu_exe_valid_i = 1'b0;
        end
    endtask

    // Compare any writeback against the head of its source's expected queue
    task automatic mon();
        wb_entry_t got, exp;
        logic      have;
        got.sid   = bus.wb_sid_o;
        got.rd    = bus.wb_rd_o;
        got.value = bus.wb_value_o;
        if (bus.wb_valid_o === 1'b1) begin
            case (got.value[63:60])
                4'h2:    have = (q_lsu.size() > 0);
                4'h3:    have = (q_mdu.size() > 0);
                default: have = (q_alu.size() > 0);
            endcase
            check("wb_pending", have, 1'b1);
            if (have) begin
                case (got.value[63:60])
                    4'h2:    exp = q_lsu.pop_front();
                    4'h3:    exp = q_mdu.pop_front();
                    default: exp = q_alu.pop_front();
                endcase
                check("wb_entry", got, exp);
                check("wb_we", bus.wb_we_o, (exp.rd != 5'd0));
            end
            last_wb = got;
        end else begin
            check("wb_hold", got, last_wb);
            check("wb_we_idle", bus.wb_we_o, 1'b0);
        end
    endtask

    task automatic step_begin();
        @(negedge clk);
        mon();
        lsu_acc = bus.lsu_valid_i & bus.lsu_ready_o;
        mdu_acc = bus.mdu_valid_i & bus.mdu_ready_o;
        if (lsu_acc) q_lsu.push_back(cur_lsu);
        if (mdu_acc) q_mdu.push_back(cur_mdu);
        if (bus.alu_exe_valid_i) q_alu.push_back(cur_alu);
        if (int'(cnt) > max_cnt) max_cnt = int'(cnt);
    endtask

    task automatic step_end();
        @(posedge clk);
        #1;
        if (lsu_acc) begin lsu_left--; lsu_seq++; end
        if (mdu_acc) begin mdu_left--; mdu_seq++; end
        lsu_acc = 1'b0;
        mdu_acc = 1'b0;
        apply();
    endtask

    task automatic cycle();
        step_begin();
        step_end();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, bus.wb_valid_o, 1'b0);
        check({tag, "_we"}, bus.wb_we_o, 1'b0);
        check({tag, "_payload"}, {bus.wb_sid_o, bus.wb_rd_o, bus.wb_value_o}, '0);
        check({tag, "_cnt"}, cnt, '0);
        check({tag, "_ovf"}, ovf, 1'b0);
        check({tag, "_ready"}, {bus.lsu_ready_o, bus.mdu_ready_o}, 2'b00);
    endtask

    initial begin
        bus.alu_exe_valid_i = 1'b0; bus.alu_sid_i = '0; bus.alu_exe_rd_i = '0; bus.alu_exe_rd_value_i = '0;
        bus.lsu_valid_i = 1'b0; bus.lsu_sid_i = '0; bus.lsu_rd_i = '0; bus.lsu_value_i = '0;
        bus.mdu_valid_i = 1'b0; bus.mdu_sid_i = '0; bus.mdu_rd_i = '0; bus.mdu_value_i = '0;
        last_wb = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // Single ALU result: two-cycle latency
        drive_alu('{sid: SB_W'(3), rd: 5'd5, value: 64'h1234});
        step_begin();
        check("alu_c0_cnt", cnt, 3'd0);
        step_end();
        step_begin();
        check("alu_c1_valid", bus.wb_valid_o, 1'b0);
        check("alu_c1_cnt", cnt, 3'd1);
        step_end();
        step_begin();
        check("alu_c2_valid", bus.wb_valid_o, 1'b1);
        check("alu_c2_we", bus.wb_we_o, 1'b1);
        check("alu_c2_rd", bus.wb_rd_o, 5'd5);
        check("alu_c2_value", bus.wb_value_o, 64'h1234);
        step_end();

        // x0 destination still completes its sid
        drive_alu('{sid: SB_W'(7), rd: 5'd0, value: 64'hBEEF});
        cycle();
        cycle();
        step_begin();
        check("x0_valid", bus.wb_valid_o, 1'b1);
        check("x0_we", bus.wb_we_o, 1'b0);
        check("x0_sid", bus.wb_sid_o, SB_W'(7));
        step_end();

        // LSU and MDU contending: strict alternation starting with LSU
        lsu_left = 4;
        mdu_left = 4;
        apply();
        for (int i = 0; i < 8; i++) begin
            step_begin();
            check("rr_lsu_ready", bus.lsu_ready_o, (i % 2 == 0));
            check("rr_mdu_ready", bus.mdu_ready_o, (i % 2 == 1));
            step_end();
        end
        repeat (3) cycle();

        // ALU stream with competing LSU/MDU: forced ALU grant caps occupancy
        max_cnt    = 0;
        alu_stream = 20;
        lsu_left   = 5;
        mdu_left   = 5;
        apply();
        for (int i = 0; i < 60; i++) begin
            step_begin();
            check("stream_cnt_le3", (cnt <= 3'd3), 1'b1);
            check("stream_ovf", ovf, 1'b0);
            if (cnt >= 3'd3) begin
                check("stream_forced", {bus.lsu_ready_o, bus.mdu_ready_o}, 2'b00);
            end
            step_end();
        end
        check("stream_max_cnt", max_cnt, 3);
        check("stream_alu_drained", q_alu.size(), 0);
        check("stream_lsu_drained", q_lsu.size(), 0);
        check("stream_mdu_drained", q_mdu.size(), 0);

        // Reset mid-operation with two buffered ALU entries and MDU held
        lsu_left   = 1;
        mdu_left   = 3;
        alu_stream = 2;
        apply();
        step_begin();
        check("pre_lsu_ready", bus.lsu_ready_o, 1'b1);
        step_end();
        step_begin();
        check("pre_mdu_ready", bus.mdu_ready_o, 1'b1);
        check("pre_cnt1", cnt, 3'd1);
        step_end();
        step_begin();
        check("pre_cnt2", cnt, 3'd2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        q_alu.delete();
        last_wb = '0;
        step_end();
        rst_n = 1'b1;
        drive_alu(mk(4'h1, 200));
        step_begin();
        check("post_rst_valid", bus.wb_valid_o, 1'b0);
        check("post_rst_mdu_ready", bus.mdu_ready_o, 1'b1);
        check("post_rst_cnt", cnt, 3'd0);
        step_end();
        step_begin();
        check("post_push_cnt", cnt, 3'd1);
        check("post_push_mdu_wait", bus.mdu_ready_o, 1'b0);
        step_end();
        repeat (6) cycle();
        check("end_alu_drained", q_alu.size(), 0);
        check("end_lsu_drained", q_lsu.size(), 0);
        check("end_mdu_drained", q_mdu.size(), 0);
        check("end_ovf", ovf, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
